// File: rtl/slug_pkg.sv
// Shared definitions for the memory-bus slice.
//   bw_state_t : bus_writer sequencing states
//   ADDR_W     : width of the shared address bus (ram/counter)
//   DATA_W     : width of the shared data bus
package slug_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRIVE = 2'd2,
    WRITE = 2'd3
  } bw_state_t;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 8;

  // True in the states where the writer owns the shared buses.
  function automatic logic bw_owns_bus(input bw_state_t s);
    return (s == DRIVE) || (s == WRITE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-in first-out queue with registered pointers.
// Ports:
//   wclk   clock
//   rst    synchronous active-low reset (pointers only; storage is not reset)
//   push   write din when not full
//   din    entry to enqueue
//   pop    drop the head entry when not empty
//   head   current head entry (valid while !empty)
//   full   DEPTH entries held
//   empty  no entries held
//   count  number of entries held
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo #(
  parameter int W     = 28,
  parameter int DEPTH = 4
) (
  input  logic                     wclk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [PW:0]  wptr;
  logic [PW:0]  rptr;

  always_ff @(posedge wclk) begin
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + PTR_ONE;
      if (pop && !empty)
        rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge wclk) begin
    if (push && !full)
      mem[wptr[PW-1:0]] <= din;
  end

  assign head  = mem[rptr[PW-1:0]];
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
  assign count = wptr - rptr;

endmodule

// File: rtl/bus_writer.sv
// Write-side master for the shared tri-state memory bus.
// Queues write requests and, once the arbiter grants the bus, presents
// each entry for a setup cycle (DRIVE) followed by a we=1 cycle (WRITE).
// Ports:
//   wclk       clock
//   rst        synchronous active-low reset
//   req_valid  write request present
//   req_ready  queue can accept (= !full)
//   req_addr   target address
//   req_data   byte to write
//   bus_req    bus ownership request
//   bus_gnt    bus granted by arbiter
//   addr       shared tri-state address bus (high-Z unless owned)
//   data       shared tri-state data bus (high-Z unless owned)
//   we         RAM write enable
//   busy       queue non-empty or sequencer not idle
//   wr_count   16-bit count of WRITE cycles, wraps; only present when
//              BUS_WRITER_STATS_EN is defined
module bus_writer
  import slug_pkg::*;
#(
  parameter int AW    = ADDR_W,
  parameter int DW    = DATA_W,
  parameter int DEPTH = 4
) (
  input  logic          wclk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_data,
  output logic          bus_req,
  input  logic          bus_gnt,
  inout  wire  [AW-1:0] addr,
  inout  wire  [DW-1:0] data,
  output logic          we,
  output logic          busy
`ifdef BUS_WRITER_STATS_EN
  ,
  output logic [15:0]   wr_count
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] ONE_ENTRY = 1;

  bw_state_t state, state_n;

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] fifo_cnt;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic          drv;
  logic          more_after_pop;

  assign req_ready = !full;
  assign push      = req_valid && !full;
  // The entry is consumed at the edge that ends its WRITE cycle.
  assign pop       = (state == WRITE);

  sync_fifo #(
    .W     (AW + DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .wclk  (wclk),
    .rst   (rst),
    .push  (push),
    .din   ({req_addr, req_data}),
    .pop   (pop),
    .head  ({head_addr, head_data}),
    .full  (full),
    .empty (empty),
    .count (fifo_cnt)
  );

  // A same-cycle push keeps the queue non-empty even when popping the last entry.
  assign more_after_pop = (fifo_cnt != ONE_ENTRY) || push;

  always_ff @(posedge wclk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (!empty) state_n = REQ;
      REQ:     if (bus_gnt) state_n = DRIVE;
      DRIVE:   state_n = bus_gnt ? WRITE : REQ;
      WRITE:   state_n = (more_after_pop && bus_gnt) ? DRIVE : IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Output flops are loaded from the next state so they line up with the
  // state register yet come straight off a flop.
  always_ff @(posedge wclk) begin
    if (!rst) begin
      bus_req <= 1'b0;
      drv     <= 1'b0;
      we      <= 1'b0;
    end else begin
      bus_req <= (state_n != IDLE);
      drv     <= bw_owns_bus(state_n);
      we      <= (state_n == WRITE);
    end
  end

  assign addr = drv ? head_addr : {AW{1'bz}};
  assign data = drv ? head_data : {DW{1'bz}};
  assign busy = !empty || (state != IDLE);

`ifdef BUS_WRITER_STATS_EN
  logic [15:0] wr_count_q;

  always_ff @(posedge wclk) begin
    if (!rst)
      wr_count_q <= 16'd0;
    else if (we)
      wr_count_q <= wr_count_q + 16'd1;
  end

  assign wr_count = wr_count_q;
`endif

endmodule

// File: tb/tb_bus_writer.sv
// Directed bench for bus_writer: reset, single write, burst, grant
// withdrawal during DRIVE, reset mid-burst, and the optional write counter.
module tb_bus_writer;

  logic        wclk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        bus_gnt = 1'b0;
  logic [19:0] req_addr = '0;
  logic [7:0]  req_data = '0;
  wire         req_ready;
  wire         bus_req;
  wire         we;
  wire         busy;
  wire  [19:0] addr;
  wire  [7:0]  data;
`ifdef BUS_WRITER_STATS_EN
  wire  [15:0] wr_count;
`endif

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // RAM model and write log
  logic [7:0]  ram_d  [256];
  logic        ram_wr [256];
  logic [19:0] log_a  [64];
  logic [7:0]  log_d  [64];
  int          wr_n = 0;

  bus_writer dut (
    .wclk      (wclk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .bus_req   (bus_req),
    .bus_gnt   (bus_gnt),
    .addr      (addr),
    .data      (data),
    .we        (we),
    .busy      (busy)
`ifdef BUS_WRITER_STATS_EN
    ,
    .wr_count  (wr_count)
`endif
  );

  always #5 wclk = ~wclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram_wr[i] = 1'b0;
  end

  always @(posedge wclk) begin
    if (we === 1'b1) begin
      chk("gnt_held_in_write", {31'd0, bus_gnt}, 32'd1);
      ram_d[addr[7:0]]  <= data;
      ram_wr[addr[7:0]] <= 1'b1;
      if (wr_n < 64) begin
        log_a[wr_n] <= addr;
        log_d[wr_n] <= data;
      end
      wr_n <= wr_n + 1;
    end
  end

  // Push one entry and wait (bounded) for the writer to go idle.
  task automatic do_write(input logic [19:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 20 && busy === 1'b1; k++) tick();
    chk("dw_idle", {31'd0, busy}, 32'd0);
  endtask

  logic [19:0] b_addr [4];
  logic [7:0]  b_data [4];
  int          wr_start;

  initial begin
    b_addr[0] = 20'h00010; b_data[0] = 8'h5A;
    b_addr[1] = 20'h00011; b_data[1] = 8'hC3;
    b_addr[2] = 20'h00012; b_data[2] = 8'h0F;
    b_addr[3] = 20'h00013; b_data[3] = 8'hF0;

    // Reset held 3 cycles with a request pending
    #1;
    rst       = 1'b0;
    req_valid = 1'b1;
    req_addr  = 20'h00555;
    req_data  = 8'h11;
    bus_gnt   = 1'b1;
    repeat (3) tick();
    chk("rst_ready",  {31'd0, req_ready}, 32'd1);
    chk("rst_busreq", {31'd0, bus_req}, 32'd0);
    chk("rst_we",     {31'd0, we}, 32'd0);
    chk("rst_busy",   {31'd0, busy}, 32'd0);
    chk("rst_addr_z", {31'd0, addr === 20'bz}, 32'd1);
    chk("rst_data_z", {31'd0, data === 8'bz}, 32'd1);
    req_valid = 1'b0;
    rst       = 1'b1;
    tick();
    tick();
    chk("post_rst_busy",   {31'd0, busy}, 32'd0);
    chk("post_rst_busreq", {31'd0, bus_req}, 32'd0);

    // Single write with grant tied high
    req_valid = 1'b1;
    req_addr  = 20'h00123;
    req_data  = 8'hA5;
    tick();                                   // edge 0: push
    req_valid = 1'b0;
    chk("s0_busy",   {31'd0, busy}, 32'd1);
    chk("s0_busreq", {31'd0, bus_req}, 32'd0);
    tick();                                   // edge 1: REQ
    chk("s1_busreq", {31'd0, bus_req}, 32'd1);
    chk("s1_addr_z", {31'd0, addr === 20'bz}, 32'd1);
    tick();                                   // edge 2: DRIVE
    chk("s2_we",   {31'd0, we}, 32'd0);
    chk("s2_addr", {12'd0, addr}, 32'h00123);
    chk("s2_data", {24'd0, data}, 32'hA5);
    tick();                                   // edge 3: WRITE
    chk("s3_we",   {31'd0, we}, 32'd1);
    chk("s3_addr", {12'd0, addr}, 32'h00123);
    chk("s3_data", {24'd0, data}, 32'hA5);
    tick();                                   // edge 4: RAM latches, back to IDLE
    chk("s4_we",     {31'd0, we}, 32'd0);
    chk("s4_busy",   {31'd0, busy}, 32'd0);
    chk("s4_busreq", {31'd0, bus_req}, 32'd0);
    chk("s4_data_z", {31'd0, data === 8'bz}, 32'd1);
    chk("s4_ram",    {24'd0, ram_d[8'h23]}, 32'hA5);

    // Burst of 4 back-to-back pushes
    wr_start = wr_n;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr  = b_addr[i];
      req_data  = b_data[i];
      tick();                                 // edges 0..3
    end
    chk("b_full_ready", {31'd0, req_ready}, 32'd0);
    chk("b3_we",        {31'd0, we}, 32'd1);
    req_valid = 1'b0;
    for (int e = 4; e <= 10; e++) begin
      tick();
      chk($sformatf("b%0d_we", e),     {31'd0, we}, {31'd0, (e % 2 == 1) && (e <= 9)});
      chk($sformatf("b%0d_busreq", e), {31'd0, bus_req}, {31'd0, e < 10});
    end
    chk("b_count", wr_n - wr_start, 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("b_order_a%0d", i), {12'd0, log_a[wr_start + i]}, {12'd0, b_addr[i]});
      chk($sformatf("b_order_d%0d", i), {24'd0, log_d[wr_start + i]}, {24'd0, b_data[i]});
    end

    // Grant withdrawn during DRIVE for 2 cycles
    wr_start  = wr_n;
    req_valid = 1'b1;
    req_addr  = 20'h0ABCD;
    req_data  = 8'h3C;
    tick();                                   // edge 0
    req_valid = 1'b0;
    tick();                                   // edge 1: REQ
    tick();                                   // edge 2: DRIVE
    chk("g2_addr", {12'd0, addr}, 32'h0ABCD);
    bus_gnt = 1'b0;
    tick();                                   // edge 3: back to REQ
    chk("g3_addr_z", {31'd0, addr === 20'bz}, 32'd1);
    chk("g3_data_z", {31'd0, data === 8'bz}, 32'd1);
    chk("g3_we",     {31'd0, we}, 32'd0);
    chk("g3_busreq", {31'd0, bus_req}, 32'd1);
    tick();                                   // edge 4: still REQ
    chk("g4_addr_z", {31'd0, addr === 20'bz}, 32'd1);
    chk("g4_busy",   {31'd0, busy}, 32'd1);
    bus_gnt = 1'b1;
    tick();                                   // edge 5: DRIVE
    chk("g5_we", {31'd0, we}, 32'd0);
    tick();                                   // edge 6: WRITE
    chk("g6_we",   {31'd0, we}, 32'd1);
    chk("g6_addr", {12'd0, addr}, 32'h0ABCD);
    chk("g6_data", {24'd0, data}, 32'h3C);
    tick();                                   // edge 7
    chk("g7_busy",  {31'd0, busy}, 32'd0);
    chk("g7_count", wr_n - wr_start, 32'd1);
    chk("g7_ram",   {24'd0, ram_d[8'hCD]}, 32'h3C);

    // Reset during WRITE of entry 2 of 4
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1;
      req_addr  = 20'h00200 + 20'(i);
      req_data  = 8'h80 + 8'(i);
      tick();                                 // edges 0..3
    end
    req_valid = 1'b0;
    tick();                                   // edge 4: DRIVE entry 2
    tick();                                   // edge 5: WRITE entry 2
    chk("r5_we",   {31'd0, we}, 32'd1);
    chk("r5_addr", {12'd0, addr}, 32'h00201);
    rst = 1'b0;
    tick();                                   // edge 6: reset
    chk("r6_we",     {31'd0, we}, 32'd0);
    chk("r6_busreq", {31'd0, bus_req}, 32'd0);
    chk("r6_busy",   {31'd0, busy}, 32'd0);
    chk("r6_ready",  {31'd0, req_ready}, 32'd1);
    chk("r6_addr_z", {31'd0, addr === 20'bz}, 32'd1);
    rst = 1'b1;
    wr_start = wr_n;
    repeat (10) tick();
    chk("r_no_more_writes", wr_n - wr_start, 32'd0);
    chk("r_entry3_absent",  {31'd0, ram_wr[8'h02]}, 32'd0);
    chk("r_entry4_absent",  {31'd0, ram_wr[8'h03]}, 32'd0);

`ifdef BUS_WRITER_STATS_EN
    // Write counter
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("st_rst", {16'd0, wr_count}, 32'd0);
    do_write(20'h00040, 8'h01);
    do_write(20'h00041, 8'h02);
    do_write(20'h00042, 8'h03);
    chk("st_three", {16'd0, wr_count}, 32'd3);
    force dut.wr_count_q = 16'hFFFF;
    tick();
    release dut.wr_count_q;
    chk("st_preload", {16'd0, wr_count}, 32'h0000FFFF);
    do_write(20'h00043, 8'h04);
    chk("st_wrap", {16'd0, wr_count}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
